// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the sequential wide add/subtract engine.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_DEFAULT = 16;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Index width for the slice counter; never narrower than one bit.
    function automatic int calc_idx_w(input int nslice);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < nslice) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/addsub64_seq_slice.sv
// Purely combinational SLICE-bit adder with carry in/out; no operand inversion.
module slice_addsub #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    logic [SLICE:0] total_s;

    assign total_s = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
    assign s       = total_s[SLICE-1:0];
    assign co      = total_s[SLICE];

endmodule

// File: rtl/addsub64_seq.sv
// Wide add/subtract processed one slice per cycle through a single slice adder,
// with valid/ready handshakes on both sides and carry/overflow flags.
module addsub64_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDX_W  = calc_idx_w(NSLICE);

    state_t                        state_r;
    state_t                        state_s;
    logic [IDX_W-1:0]              k_r;
    logic                          carry_r;
    logic [NSLICE-1:0][SLICE-1:0]  a_r;
    logic [NSLICE-1:0][SLICE-1:0]  b_r;
    logic [NSLICE-1:0][SLICE-1:0]  sum_r;
    logic                          cout_r;
    logic                          ovf_r;
    logic                          in_ready_r;
    logic                          out_valid_r;
    logic                          last_s;
    logic [SLICE-1:0]              slice_sum_s;
    logic                          slice_co_s;

    assign last_s = (k_r == IDX_W'(NSLICE - 1));

    slice_addsub #(
        .SLICE (SLICE)
    ) u_slice (
        .x  (a_r[k_r]),
        .y  (b_r[k_r]),
        .ci (carry_r),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // Next-state decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus registered handshake outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Operand latch, per-slice accumulation and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r     <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r     <= a;
                        b_r     <= b ^ {WIDTH{sub}};
                        carry_r <= sub;
                        k_r     <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    sum_r[k_r] <= slice_sum_s;
                    carry_r    <= slice_co_s;
                    k_r        <= k_r + IDX_W'(1);
                    if (last_s) begin
                        cout_r <= slice_co_s;
                        // Same-sign operands producing a result of the other sign.
                        ovf_r  <= (a_r[NSLICE-1][SLICE-1] == b_r[NSLICE-1][SLICE-1]) &&
                                  (slice_sum_s[SLICE-1] != a_r[NSLICE-1][SLICE-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_addsub64_seq.sv
// Directed self-checking bench for addsub64_seq with hand-computed expectations.
module tb_addsub64_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int errors;
    int checks;
    int lat;

    addsub64_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present one transaction for a single accept edge.
    task automatic start_txn(input logic [63:0] ta, input logic [63:0] tb, input logic ts);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a        = ta;
        b        = tb;
        sub      = ts;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (!out_valid && l < 20) begin
            tick();
            l++;
        end
        check("out_valid_seen", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_vec(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                           input logic ts, input logic [63:0] es, input logic ec, input logic eo);
        int l;
        start_txn(ta, tb, ts);
        wait_out(l);
        check({tag, "_lat"}, 64'(l), 64'd4);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
        check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
        handshake();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 64'd0;
        b         = 64'd0;
        sub       = 1'b0;

        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        run_vec("ripple", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0);
        run_vec("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        run_vec("sub_borrow", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_vec("sub_noborrow", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);
        run_vec("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_vec("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Input isolation during RUN, then backpressure in DONE.
        start_txn(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("run_in_ready", {63'd0, in_ready}, 64'd0);
            in_valid = 1'b1;
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            sub      = ~sub;
            tick();
            lat++;
        end
        check("iso_lat", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            a   = {$urandom, $urandom};
            sub = ~sub;
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_sum", sum, 64'h2222_2222_2222_2211);
            check("bp_cout", {63'd0, cout}, 64'd0);
            check("bp_ovf", {63'd0, ovf}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        handshake();

        // Reset while slice 2 is being processed.
        start_txn(64'd1, 64'd1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrun_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrun_sum", sum, 64'd0);
        check("midrun_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        tick();
        check("midrun_in_ready_after", {63'd0, in_ready}, 64'd1);
        run_vec("fresh", 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
